// File: rtl/memoria_responder.sv
// Word-addressed memory responder: single-port register array with a fixed-latency read pipeline.
// Optional misalignment checking is compiled in with `define ALIGN_CHECK_EN.
module memoria_responder #(
  parameter int ADDR_BITS    = 8,
  parameter int READ_LATENCY = 2,
  parameter int DATA_W       = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              MemReq,
  input  logic              MemReadWrite,
  input  logic [31:0]       Address,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] MemData,
  output logic              ReadValid,
  output logic              Busy,
  output logic              AlignErr
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [DATA_W-1:0]       mem_r [DEPTH];
  logic [READ_LATENCY-1:0] vld_r;
  logic [DATA_W-1:0]       dat_r [READ_LATENCY];

  logic [ADDR_BITS-1:0] idx_s;
  logic                 misalign_s;
  logic                 rd_en_s;
  logic                 wr_en_s;
  logic [DATA_W-1:0]    rd_word_s;
  logic                 unused_s;

  assign idx_s    = Address[ADDR_BITS+1:2];
  assign unused_s = ^{Address[31:ADDR_BITS+2], Address[1:0]};
  assign Busy     = |vld_r;

  // Request decode: misalignment, read/write enables and the word sampled at issue
  always_comb begin
    misalign_s = 1'b0;
`ifdef ALIGN_CHECK_EN
    misalign_s = (Address[1:0] != 2'b00);
`else
    misalign_s = 1'b0;
`endif
    rd_en_s = MemReq & ~MemReadWrite;
    wr_en_s = MemReq & MemReadWrite & ~reset & ~misalign_s;
    if (misalign_s) begin
      rd_word_s = {DATA_W{1'b0}};
    end else begin
      rd_word_s = mem_r[idx_s];
    end
  end

  // Storage array; deliberately not cleared by reset
  always_ff @(posedge clock) begin
    if (wr_en_s) begin
      mem_r[idx_s] <= WriteData;
    end
  end

  // Read pipeline, return register and sticky alignment flag
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_r <= {READ_LATENCY{1'b0}};
      for (int k = 0; k < READ_LATENCY; k++) begin
        dat_r[k] <= {DATA_W{1'b0}};
      end
      MemData   <= {DATA_W{1'b0}};
      ReadValid <= 1'b0;
      AlignErr  <= 1'b0;
    end else begin
      vld_r[0] <= rd_en_s;
      dat_r[0] <= rd_word_s;
      for (int k = 1; k < READ_LATENCY; k++) begin
        vld_r[k] <= vld_r[k-1];
        dat_r[k] <= dat_r[k-1];
      end
      ReadValid <= vld_r[READ_LATENCY-1];
      if (vld_r[READ_LATENCY-1]) begin
        MemData <= dat_r[READ_LATENCY-1];
      end
      if (MemReq && misalign_s) begin
        AlignErr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_memoria_responder.sv
// Self-checking bench for memoria_responder: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_memoria_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 256;
`ifdef ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        MemReq = 1'b0;
  logic        MemReadWrite = 1'b0;
  logic [31:0] Address = 32'd0;
  logic [31:0] WriteData = 32'd0;
  logic [31:0] MemData;
  logic        ReadValid;
  logic        Busy;
  logic        AlignErr;

  memoria_responder #(.ADDR_BITS(8), .READ_LATENCY(LAT), .DATA_W(32)) dut (
    .clock(clock), .reset(reset), .MemReq(MemReq), .MemReadWrite(MemReadWrite),
    .Address(Address), .WriteData(WriteData), .MemData(MemData),
    .ReadValid(ReadValid), .Busy(Busy), .AlignErr(AlignErr)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          due;
    logic [31:0] data;
  } ret_t;

  logic [31:0] ref_mem [DEPTH];
  ret_t        pend [$];
  logic [31:0] exp_data = 32'd0;
  logic        exp_err = 1'b0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, advance the model at the edge, then compare all outputs.
  task automatic step(input logic rst, input logic req, input logic rw,
                      input logic [31:0] addr, input logic [31:0] wd);
    int   idx;
    logic mis;
    logic exp_valid;
    reset = rst; MemReq = req; MemReadWrite = rw; Address = addr; WriteData = wd;
    @(posedge clock);
    cyc++;
    idx = int'(addr >> 2) % DEPTH;
    mis = ALIGN && (addr % 4 != 0);
    if (rst) begin
      pend.delete();
      exp_data = 32'd0;
      exp_err  = 1'b0;
    end else if (req) begin
      if (mis) exp_err = 1'b1;
      if (rw) begin
        if (!mis) ref_mem[idx] = wd;
      end else begin
        pend.push_back('{due: cyc + LAT, data: (mis ? 32'd0 : ref_mem[idx])});
      end
    end
    exp_valid = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      exp_valid = 1'b1;
      exp_data  = pend[0].data;
      void'(pend.pop_front());
    end
    #1;
    check("read_valid", {31'd0, ReadValid}, {31'd0, exp_valid});
    check("mem_data", MemData, exp_data);
    check("busy", {31'd0, Busy}, {31'd0, (pend.size() > 0)});
    check("align_err", {31'd0, AlignErr}, {31'd0, exp_err});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, $urandom, $urandom);
  endtask

  initial begin
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b1, 1'b1, 32'h40, 32'h1234);

    // Preload every word so the model never has to reason about unknown contents
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b1, 32'(i * 4), $urandom);
    step(1'b0, 1'b1, 1'b1, 32'h0, 32'd1);
    step(1'b0, 1'b1, 1'b1, 32'h4, 32'd2);
    step(1'b0, 1'b1, 1'b1, 32'h8, 32'd3);
    step(1'b0, 1'b1, 1'b1, 32'h20, 32'd5);

    // Write then read back with fixed latency
    step(1'b0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    step(1'b0, 1'b1, 1'b0, 32'h10, 32'd0);
    idle(1);
    check("t1_no_early_valid", {31'd0, ReadValid}, 32'd0);
    idle(1);
    check("t1_valid", {31'd0, ReadValid}, 32'd1);
    check("t1_data", MemData, 32'hDEADBEEF);

    // Back-to-back reads
    step(1'b0, 1'b1, 1'b0, 32'h0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'h4, 32'd0);
    check("t2_busy", {31'd0, Busy}, 32'd1);
    step(1'b0, 1'b1, 1'b0, 32'h8, 32'd0);
    check("t2_data1", MemData, 32'd1);
    idle(1);
    check("t2_data2", MemData, 32'd2);
    idle(1);
    check("t2_data3", MemData, 32'd3);
    idle(1);

    // Read sampled at issue, unaffected by a following write
    step(1'b0, 1'b1, 1'b0, 32'h20, 32'd0);
    step(1'b0, 1'b1, 1'b1, 32'h20, 32'd9);
    idle(1);
    check("t3_old", MemData, 32'd5);
    step(1'b0, 1'b1, 1'b0, 32'h20, 32'd0);
    idle(2);
    check("t3_new", MemData, 32'd9);

    // Address wrap
    step(1'b0, 1'b1, 1'b1, 32'h400, 32'd7);
    step(1'b0, 1'b1, 1'b0, 32'h000, 32'd0);
    idle(2);
    check("t4_wrap", MemData, 32'd7);

    // Reset mid-flight drops the return but keeps the array
    step(1'b0, 1'b1, 1'b1, 32'h30, 32'hA5);
    step(1'b0, 1'b1, 1'b0, 32'h30, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    idle(3);
    check("t5_data_cleared", MemData, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'h30, 32'd0);
    idle(2);
    check("t5_array_kept", MemData, 32'hA5);

`ifdef ALIGN_CHECK_EN
    step(1'b0, 1'b1, 1'b1, 32'h10, 32'h77);
    step(1'b0, 1'b1, 1'b1, 32'h12, 32'h55);
    check("t6_err_set", {31'd0, AlignErr}, 32'd1);
    step(1'b0, 1'b1, 1'b0, 32'h12, 32'd0);
    idle(2);
    check("t6_misaligned_read", MemData, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'h10, 32'd0);
    idle(2);
    check("t6_word_kept", MemData, 32'h77);
    check("t6_err_sticky", {31'd0, AlignErr}, 32'd1);
`endif

    // Random interleaved traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom, $urandom);
    end
    idle(LAT + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
